// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//
// Parametrised multi-read-port register file for the mini-MIPS datapath.
// It takes read addresses from decode and the write port from writeback.
//
// Storage is a plain array with no reset, so it can map onto RAM.
// A walker FSM writes zero to every entry, one entry per clock:
//   - after reset (INIT walk);
//   - on request (CLEAR walk).
// While a walk is running:
//   - the clear engine owns the array;
//   - all reads return zero;
//   - external writes are discarded and flagged on o_wr_dropped.
//
// Optional feature, selected by the RF_BYPASS_EN macro:
//   defined   : a read of the address being written in the same cycle
//               returns the merged write value (write bytes on enabled
//               lanes, stored bytes elsewhere).
//   undefined : same-cycle reads return the pre-write contents; the new
//               value is visible from the next cycle.
//
// Parameters
//   DATA_W    entry width in bits, multiple of 8
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   NUM_RD    number of independent read ports (>= 1)
//   ZERO_REG  1: entry 0 reads as zero and writes to it are dropped silently
//
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_rd_addr      packed read addresses, port i = [i*ADDR_W +: ADDR_W]
//   o_rd_data      packed read data,      port i = [i*DATA_W +: DATA_W]
//   i_wr_en        write request
//   i_wr_addr      write address
//   i_wr_data      write data
//   i_wr_be        byte enables, bit b covers i_wr_data[8b+7:8b]
//   i_clr_req      request a full clear (one-cycle pulse is enough)
//   o_busy         1 while the clear engine owns the array
//   o_wr_dropped   registered pulse: the previous-cycle write was discarded
// ---------------------------------------------------------------------------
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  input  logic                     i_wr_en,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic [DATA_W/8-1:0]      i_wr_be,
  input  logic                     i_clr_req,
  output logic                     o_busy,
  output logic                     o_wr_dropped
);

  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int NUM_BYTES = DATA_W / 8;

  // DEPTH is a power of two, so the last entry index is all ones.
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_ptr;
  logic                r_busy;
  logic                r_wrDropped;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_wrToZero;
  logic                w_wrAccept;
  logic [DATA_W-1:0]   w_wrMerged;

  // Writes to entry 0 vanish when it is hardwired to zero.
  assign w_wrToZero = (ZERO_REG != 0) && (i_wr_addr == '0);

  // A write is accepted only when the walker is idle and the target is not
  // the hardwired zero entry. An all-zero byte-enable is still "accepted":
  // it simply rewrites the stored word.
  assign w_wrAccept = (r_state == ST_IDLE) && i_wr_en && !w_wrToZero;

  // Byte-lane merge of the write data with the stored word.
  // This single value feeds both the array update and the optional bypass,
  // so the two always agree.
  always_comb begin
    w_wrMerged = r_mem[i_wr_addr];
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (i_wr_be[b]) begin
        w_wrMerged[b*8 +: 8] = i_wr_data[b*8 +: 8];
      end
    end
  end

  // Control FSM for the walker.
  // Notes:
  //   - busy is registered and always equals (next state != IDLE), so it
  //     rises the cycle after clr_req is seen in IDLE;
  //   - clr_req is ignored while a walk is running;
  //   - a discarded write is flagged one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_ptr       <= '0;
      r_busy      <= 1'b1;
      r_wrDropped <= 1'b0;
    end else begin
      r_wrDropped <= i_wr_en && r_busy;
      case (r_state)
        ST_INIT, ST_CLEAR: begin
          if (r_ptr == PTR_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        ST_IDLE: begin
          if (i_clr_req) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // Array update, deliberately without a reset so it stays RAM-inferable.
  // The walker and the write port are mutually exclusive by state, so a
  // single write port is enough.
  always_ff @(posedge clk) begin
    if (r_state != ST_IDLE) begin
      r_mem[r_ptr] <= '0;
    end else if (w_wrAccept) begin
      r_mem[i_wr_addr] <= w_wrMerged;
    end
  end

  // Independent combinational read ports.
  // Priority on each port:
  //   1. busy or the hardwired-zero entry forces 0;
  //   2. otherwise, with RF_BYPASS_EN, an accepted same-cycle write to the
  //      same address returns the merged value;
  //   3. otherwise the stored word is returned.
  // Walker writes never bypass, because reads are forced to 0 while busy.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_word;

    assign w_addr = i_rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      w_word = r_mem[w_addr];
`ifdef RF_BYPASS_EN
      if (w_wrAccept && (w_addr == i_wr_addr)) begin
        w_word = w_wrMerged;
      end
`endif
      if (r_busy || ((ZERO_REG != 0) && (w_addr == '0))) begin
        w_word = '0;
      end
    end

    assign o_rd_data[p*DATA_W +: DATA_W] = w_word;
  end

  assign o_busy       = r_busy;
  assign o_wr_dropped = r_wrDropped;

endmodule
